wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Write-back stage: final pipeline stage of the MIPS core; sole driver of the 32-entry register file write port (we, write_addr, write_data).
- Accepts ALU results and load requests from the MEM stage.
- Waits on data memory for loads (FSM handshake), formats load data (byte/half, sign/zero extend, big-endian lanes), then issues exactly one write per retired instruction.

Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 5, register address width (32 registers)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  MEM stage presents an instruction this cycle
- in_wreg  in  1  instruction writes a register
- in_waddr  in  ADDR_W  destination register
- in_wdata  in  DATA_W  ALU/move result (non-load)
- in_is_load  in  1  instruction is a load
- in_load_type  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5-7 reserved
- in_byte_off  in  2  effective address [1:0]
- mem_rdata  in  DATA_W  data memory read word
- mem_ready  in  1  mem_rdata valid this cycle
- flush  in  1  kill in-flight/incoming instruction
- stall_req  out  1  hold upstream stages
- wb_we  out  1  register file write enable
- wb_waddr  out  ADDR_W  register file write address
- wb_wdata  out  DATA_W  register file write data

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; wb_we=0, wb_waddr=0, wb_wdata=0; stall_req=0. Overrides all inputs, including mid-load.
- FSM states: IDLE, LOAD_WAIT.
- IDLE, in_valid=1, in_is_load=0, flush=0:
  - Next edge: wb_we = in_wreg && in_waddr!=0; wb_waddr=in_waddr; wb_wdata=in_wdata.
  - Latency 1 cycle; back-to-back every cycle.
- IDLE, in_valid=1, in_is_load=1, flush=0:
  - Capture waddr, wreg, load_type, byte_off; go LOAD_WAIT.
  - wb_we=0 next cycle.
- IDLE with in_valid=0 or flush=1: wb_we=0 next cycle; nothing captured.
- LOAD_WAIT:
  - stall_req=1 (combinational from state); in_valid ignored.
  - mem_ready=1 and flush=0: next edge wb_we = wreg && waddr!=0, wb_waddr=captured addr, wb_wdata=formatted data; return IDLE. Load-use latency 1 cycle after mem_ready.
  - mem_ready=0: remain; wb_we=0.
  - flush=1 (with or without mem_ready): abandon load, IDLE, wb_we=0. Flush wins over mem_ready.
- wb_we is high only in the cycle following a retirement; wb_waddr/wb_wdata hold their last values while wb_we=0.
- Load formatting (big-endian; off 0 = bits 31:24):
  - LB/LBU: byte at lane off; sign/zero-extend to 32.
  - LH/LHU: off[1]=0 selects bits 31:16, off[1]=1 selects bits 15:0; off[0] ignored; sign/zero-extend.
  - LW: full word; off ignored.
  - Reserved types 5-7: complete handshake, wb_we=0.
- Writes to register 0 are always suppressed (wb_we=0).
- No other arithmetic; widths are fixed.

Optional Feature:
- Macro: WB_STAT_EN
- Defined:
  - Adds outputs stat_retired (32 bits): increments once per cycle with wb_we=1.
  - Adds stat_stall (32 bits): increments each cycle in LOAD_WAIT.
  - Both wrap modulo 2^32; cleared by rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- ALU path: in_valid=1, wreg=1, waddr=5, wdata=0x12345678 -> next cycle wb_we=1, wb_waddr=5, wb_wdata=0x12345678; stall_req=0 throughout.
- R0 suppression: waddr=0, wdata=0xFFFFFFFF -> wb_we=0 next cycle.
- LB sign-extend with wait: is_load=1, type LB, off=1, waddr=8; mem_ready low 3 cycles then high with mem_rdata=0x11F23344 -> stall_req=1 for 4 cycles (3 low + ready cycle); next cycle wb_we=1, wb_waddr=8, wb_wdata=0xFFFFFFF2.
- LHU/LH: type LHU, off=2, rdata=0xAAAA8001 -> wb_wdata=0x00008001; type LH, off=0, same rdata -> wb_wdata=0xFFFFAAAA.
- Flush mid-load: load to r9 in LOAD_WAIT; flush=1 and mem_ready=1 same cycle -> state IDLE, stall_req=0 next cycle, no wb_we pulse for r9.
- Reset mid-load: rst=1 in LOAD_WAIT -> next cycle wb_we=0, wb_waddr=0, wb_wdata=0, stall_req=0; with WB_STAT_EN both counters read 0.

Source files
------------

// File: rtl/wb_unit.sv
// Write-back stage: retires ALU results and loads, formats load data, and owns the register file write port.
// Optional WB_STAT_EN adds retired-write and load-stall counters.
module wb_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_wreg,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_is_load,
  input  logic [2:0]        in_load_type,
  input  logic [1:0]        in_byte_off,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              flush,
`ifdef WB_STAT_EN
  output logic [31:0]       stat_retired,
  output logic [31:0]       stat_stall,
`endif
  output logic              stall_req,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  typedef struct packed {
    logic              wreg;
    logic [ADDR_W-1:0] waddr;
    logic [2:0]        ltype;
    logic [1:0]        off;
  } ld_req_t;

  state_t            state_q, state_d;
  ld_req_t           req_q;
  logic              cap;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [7:0]        lb;
  logic [15:0]       lh;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ok;

  assign stall_req = (state_q == LOAD_WAIT);

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    lb      = '0;
    ld_ok   = 1'b1;
    ld_data = '0;
    case (req_q.off)
      2'd0:    lb = mem_rdata[31:24];
      2'd1:    lb = mem_rdata[23:16];
      2'd2:    lb = mem_rdata[15:8];
      default: lb = mem_rdata[7:0];
    endcase
    lh = req_q.off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (req_q.ltype)
      3'd0:    ld_data = {{(DATA_W-8){lb[7]}}, lb};
      3'd1:    ld_data = {{(DATA_W-8){1'b0}}, lb};
      3'd2:    ld_data = {{(DATA_W-16){lh[15]}}, lh};
      3'd3:    ld_data = {{(DATA_W-16){1'b0}}, lh};
      3'd4:    ld_data = mem_rdata;
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    we_d    = 1'b0;
    waddr_d = wb_waddr;
    wdata_d = wb_wdata;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          if (in_is_load) begin
            cap     = 1'b1;
            state_d = LOAD_WAIT;
          end else if (in_wreg && in_waddr != '0) begin
            we_d    = 1'b1;
            waddr_d = in_waddr;
            wdata_d = in_wdata;
          end
        end
      end
      LOAD_WAIT: begin
        // Flush beats mem_ready: the load is dropped without a write.
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          state_d = IDLE;
          if (req_q.wreg && req_q.waddr != '0 && ld_ok) begin
            we_d    = 1'b1;
            waddr_d = req_q.waddr;
            wdata_d = ld_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else begin
      state_q  <= state_d;
      wb_we    <= we_d;
      wb_waddr <= waddr_d;
      wb_wdata <= wdata_d;
      if (cap) req_q <= '{wreg: in_wreg, waddr: in_waddr, ltype: in_load_type, off: in_byte_off};
    end
  end

`ifdef WB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_retired <= '0;
      stat_stall   <= '0;
    end else begin
      if (wb_we) stat_retired <= stat_retired + 32'd1;
      if (state_q == LOAD_WAIT) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed test-plan scenarios plus a randomized run against a reference model.
module tb_wb_unit;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_wreg, in_is_load, mem_ready, flush;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata, mem_rdata;
  logic [2:0]  in_load_type;
  logic [1:0]  in_byte_off;
  logic        stall_req, wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
`ifdef WB_STAT_EN
  logic [31:0] stat_retired, stat_stall;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  wb_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wreg(in_wreg), .in_waddr(in_waddr),
    .in_wdata(in_wdata), .in_is_load(in_is_load), .in_load_type(in_load_type),
    .in_byte_off(in_byte_off), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .flush(flush),
`ifdef WB_STAT_EN
    .stat_retired(stat_retired), .stat_stall(stat_stall),
`endif
    .stall_req(stall_req), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst = 1'b0; in_valid = 1'b0; in_wreg = 1'b0; in_waddr = '0; in_wdata = '0;
    in_is_load = 1'b0; in_load_type = '0; in_byte_off = '0; mem_rdata = '0;
    mem_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic issue_load(input int t, input int off, input int ra);
    in_valid = 1'b1; in_is_load = 1'b1; in_wreg = 1'b1;
    in_load_type = 3'(t); in_byte_off = 2'(off); in_waddr = 5'(ra);
    cyc();
    in_valid = 1'b0; in_is_load = 1'b0;
  endtask

  // Load formatting from the rules: big-endian byte lanes, halves by off[1].
  function automatic logic [31:0] ref_load(input int t, input int off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (3 - off))) & 32'hFF;
    h = (off >= 2) ? (w & 32'hFFFF) : (w >> 16);
    case (t)
      0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      1: return b;
      2: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3: return h;
      default: return w;
    endcase
  endfunction

  task automatic test_reset();
    quiet(); rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    total++; if ({wb_we, wb_waddr, wb_wdata, stall_req} !== 39'd0) begin
      bad++; $display("FAIL reset: we=%b addr=%0d data=%h stall=%b want all 0", wb_we, wb_waddr, wb_wdata, stall_req); end
  endtask

  task automatic test_alu();
    quiet(); in_valid = 1'b1; in_wreg = 1'b1; in_waddr = 5'd5; in_wdata = 32'h12345678;
    cyc(); in_valid = 1'b0;
    total++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd5, 32'h12345678}) begin
      bad++; $display("FAIL alu: we=%b addr=%0d data=%h want 1/5/12345678", wb_we, wb_waddr, wb_wdata); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b want 0", stall_req); end
    cyc();
    total++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b0, 5'd5, 32'h12345678}) begin
      bad++; $display("FAIL alu_hold: we=%b addr=%0d data=%h want 0/5/12345678", wb_we, wb_waddr, wb_wdata); end
  endtask

  task automatic test_back_to_back();
    quiet(); in_valid = 1'b1; in_wreg = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_waddr = 5'(10 + i); in_wdata = 32'hA0000000 + 32'(i);
      cyc();
      total++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'(10 + i), 32'hA0000000 + 32'(i)}) begin
        bad++; $display("FAIL b2b%0d: we=%b addr=%0d data=%h", i, wb_we, wb_waddr, wb_wdata); end
    end
    quiet();
  endtask

  task automatic test_r0();
    quiet(); in_valid = 1'b1; in_wreg = 1'b1; in_waddr = 5'd0; in_wdata = 32'hFFFFFFFF;
    cyc(); quiet();
    total++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b0, 5'd13, 32'hA0000003}) begin
      bad++; $display("FAIL r0: we=%b addr=%0d data=%h want 0/13/a0000003", wb_we, wb_waddr, wb_wdata); end
  endtask

  task automatic test_lb_wait();
    int stalls = 0;
    quiet(); issue_load(0, 1, 8);
    total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL lb_accept_we: got %b want 0", wb_we); end
    for (int i = 0; i < 3; i++) begin
      if (stall_req === 1'b1) stalls++;
      cyc();
      total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL lb_wait_we%0d: got %b want 0", i, wb_we); end
    end
    mem_ready = 1'b1; mem_rdata = 32'h11F23344;
    if (stall_req === 1'b1) stalls++;
    cyc(); mem_ready = 1'b0;
    total++; if (stalls != 4) begin bad++; $display("FAIL lb_stall_cycles: got %0d want 4", stalls); end
    total++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd8, 32'hFFFFFFF2}) begin
      bad++; $display("FAIL lb: we=%b addr=%0d data=%h want 1/8/fffffff2", wb_we, wb_waddr, wb_wdata); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL lb_done_stall: got %b want 0", stall_req); end
  endtask

  task automatic test_lh();
    quiet(); issue_load(3, 2, 4);
    mem_ready = 1'b1; mem_rdata = 32'hAAAA8001; cyc(); mem_ready = 1'b0;
    total++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd4, 32'h00008001}) begin
      bad++; $display("FAIL lhu: we=%b addr=%0d data=%h want 1/4/00008001", wb_we, wb_waddr, wb_wdata); end
    issue_load(2, 0, 6);
    mem_ready = 1'b1; cyc(); mem_ready = 1'b0;
    total++; if ({wb_we, wb_waddr, wb_wdata} !== {1'b1, 5'd6, 32'hFFFFAAAA}) begin
      bad++; $display("FAIL lh: we=%b addr=%0d data=%h want 1/6/ffffaaaa", wb_we, wb_waddr, wb_wdata); end
  endtask

  task automatic test_reserved();
    quiet(); issue_load(6, 0, 7);
    mem_ready = 1'b1; mem_rdata = 32'h55555555; cyc(); mem_ready = 1'b0;
    total++; if ({wb_we, wb_waddr, wb_wdata, stall_req} !== {1'b0, 5'd6, 32'hFFFFAAAA, 1'b0}) begin
      bad++; $display("FAIL reserved: we=%b addr=%0d data=%h stall=%b want 0/6/ffffaaaa/0", wb_we, wb_waddr, wb_wdata, stall_req); end
  endtask

  task automatic test_flush();
    quiet(); issue_load(4, 0, 9);
    flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF; cyc(); quiet();
    total++; if ({wb_we, stall_req} !== 2'b00) begin
      bad++; $display("FAIL flush_load: we=%b stall=%b want 0/0", wb_we, stall_req); end
    cyc();
    total++; if (wb_we !== 1'b0 || wb_waddr === 5'd9) begin
      bad++; $display("FAIL flush_late: we=%b addr=%0d want no r9 write", wb_we, wb_waddr); end
    in_valid = 1'b1; in_is_load = 1'b1; flush = 1'b1; in_waddr = 5'd3; cyc(); quiet();
    total++; if ({wb_we, stall_req} !== 2'b00) begin
      bad++; $display("FAIL flush_idle: we=%b stall=%b want 0/0", wb_we, stall_req); end
  endtask

  task automatic test_reset_midload();
    quiet(); issue_load(4, 0, 12);
    rst = 1'b1; mem_ready = 1'b1; cyc(); rst = 1'b0; mem_ready = 1'b0;
    total++; if ({wb_we, wb_waddr, wb_wdata, stall_req} !== 39'd0) begin
      bad++; $display("FAIL reset_midload: we=%b addr=%0d data=%h stall=%b want all 0", wb_we, wb_waddr, wb_wdata, stall_req); end
`ifdef WB_STAT_EN
    total++; if ({stat_retired, stat_stall} !== 64'd0) begin
      bad++; $display("FAIL reset_stats: retired=%0d stall=%0d want 0/0", stat_retired, stat_stall); end
`endif
  endtask

  task automatic test_random();
    bit pending = 0, p_wreg = 0, w;
    int p_addr = 0, p_type = 0, p_off = 0;
    logic [4:0] e_addr = '0;
    logic [31:0] e_data = '0, e_ret = '0, e_stl = '0;
    logic e_we;
    quiet(); rst = 1'b1; cyc(); rst = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0); in_wreg = ($urandom_range(0, 4) != 0);
      in_waddr = 5'($urandom_range(0, 31)); in_wdata = $urandom();
      in_is_load = ($urandom_range(0, 2) == 0); in_load_type = 3'($urandom_range(0, 7));
      in_byte_off = 2'($urandom_range(0, 3)); mem_rdata = $urandom();
      mem_ready = ($urandom_range(0, 2) == 0); flush = ($urandom_range(0, 15) == 0);
      total++; if (stall_req !== pending) begin
        bad++; $display("FAIL rand_stall c%0d: got %b want %b", c, stall_req, pending); end
      if (pending) e_stl++;
      e_we = 1'b0;
      if (!pending) begin
        if (in_valid && !flush) begin
          if (in_is_load) begin
            pending = 1; p_wreg = in_wreg; p_addr = in_waddr; p_type = in_load_type; p_off = in_byte_off;
          end else begin
            w = in_wreg && in_waddr != 0;
            if (w) begin e_we = 1'b1; e_addr = in_waddr; e_data = in_wdata; end
          end
        end
      end else if (flush) begin
        pending = 0;
      end else if (mem_ready) begin
        pending = 0;
        if (p_wreg && p_addr != 0 && p_type <= 4) begin
          e_we = 1'b1; e_addr = 5'(p_addr); e_data = ref_load(p_type, p_off, mem_rdata);
        end
      end
      cyc();
      total++; if ({wb_we, wb_waddr, wb_wdata} !== {e_we, e_addr, e_data}) begin
        bad++; $display("FAIL rand_wb c%0d: got %b/%0d/%h want %b/%0d/%h", c, wb_we, wb_waddr, wb_wdata, e_we, e_addr, e_data); end
`ifdef WB_STAT_EN
      total++; if ({stat_retired, stat_stall} !== {e_ret, e_stl}) begin
        bad++; $display("FAIL rand_stats c%0d: got %0d/%0d want %0d/%0d", c, stat_retired, stat_stall, e_ret, e_stl); end
`endif
      if (e_we) e_ret++;
    end
    quiet();
  endtask

  initial begin
    quiet();
    test_reset();
    test_alu();
    test_back_to_back();
    test_r0();
    test_lb_wait();
    test_lh();
    test_reserved();
    test_flush();
    test_reset_midload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
